// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bus bundle: redirect input, instruction memory req/ack and the
// valid/ready instruction stream toward decode.
interface instr_prefetch_queue_if #(
  parameter int DBITS = 32
);
  logic             redirect;
  logic [DBITS-1:0] redirectPc;
  logic             memReq;
  logic [DBITS-1:0] memAddr;
  logic             memAck;
  logic [DBITS-1:0] memData;
  logic             instrValid;
  logic [DBITS-1:0] instrOut;
  logic [DBITS-1:0] instrPc;
  logic             instrReady;

  modport slave (
    input  redirect, redirectPc, memAck, memData, instrReady,
    output memReq, memAddr, instrValid, instrOut, instrPc
  );

  modport master (
    output redirect, redirectPc, memAck, memData, instrReady,
    input  memReq, memAddr, instrValid, instrOut, instrPc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: keeps one word read in flight to instruction
// memory and buffers {pc, instr} pairs for decode; redirects flush the queue.
module instr_prefetch_queue #(
  parameter int               DBITS    = 32,
  parameter logic [DBITS-1:0] START_PC = DBITS'('h40),
  parameter int               DEPTH    = 4
) (
  input logic                   clk,
  input logic                   res,
  instr_prefetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DBITS-1:0] pc_mem  [DEPTH];
  logic [DBITS-1:0] dat_mem [DEPTH];

  logic [DBITS-1:0] fetch_pc_q, fetch_pc_d;
  logic             req_q, req_d;
  logic [DBITS-1:0] addr_q, addr_d;
  logic             drop_q, drop_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             val_q, val_d;
  logic [DBITS-1:0] out_pc_q, out_pc_d;
  logic [DBITS-1:0] out_dat_q, out_dat_d;

  logic             ack, push, pop;
  logic [DBITS-1:0] head_pc, head_dat;

  always_comb begin
    ack        = req_q & bus.memAck;
    push       = ack & ~drop_q & ~bus.redirect;
    pop        = val_q & bus.instrReady & ~bus.redirect;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    drop_d     = drop_q;
    req_d      = req_q;
    addr_d     = addr_q;

    if (bus.redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = bus.redirectPc & ~DBITS'(3);
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      if (push) fetch_pc_d = addr_q + DBITS'(4);
    end

    // A redirect that catches a request mid-flight must discard its eventual ack.
    if (ack) drop_d = 1'b0;
    if (bus.redirect && req_q && !bus.memAck) drop_d = 1'b1;

    if (!req_q || ack) begin
      req_d  = (count_d < CW'(DEPTH));
      addr_d = fetch_pc_d;
    end

    // Head after this edge may be the word being written right now.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_pc  = addr_q;
      head_dat = bus.memData;
    end else begin
      head_pc  = pc_mem[rd_ptr_d];
      head_dat = dat_mem[rd_ptr_d];
    end

    val_d     = (count_d != '0);
    out_pc_d  = val_d ? head_pc  : out_pc_q;
    out_dat_d = val_d ? head_dat : out_dat_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= addr_q;
      dat_mem[wr_ptr_q] <= bus.memData;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      fetch_pc_q <= START_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      val_q      <= 1'b0;
      out_pc_q   <= '0;
      out_dat_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      val_q      <= val_d;
      out_pc_q   <= out_pc_d;
      out_dat_q  <= out_dat_d;
    end
  end

  assign bus.memReq     = req_q;
  assign bus.memAddr    = addr_q;
  assign bus.instrValid = val_q;
  assign bus.instrPc    = out_pc_q;
  assign bus.instrOut   = out_dat_q;
endmodule
